pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Owns the program counter and sequences next-PC selection for the single-issue CPU datapath.
- Chooses between sequential (PC+4), direct jump (instruction field spliced into the current PC) and register jump (JR).
- Inserts a one-cycle flush bubble after every taken jump.
- Handles stall hold and a halt/resume handshake with the control unit.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- JFIELD_W, 8, number of low instruction bits forming a direct-jump target (1..30).

Ports:
- in_clk  input  1  system clock, all state updates on rising edge
- in_rst_n  input  1  synchronous active-low reset
- in_J  input  1  jump request from decode
- in_JR  input  1  with in_J: register jump (target = in_a)
- in_a  input  32  register-file operand for JR
- in_is  input  32  instruction word currently in decode
- in_stall  input  1  hold PC and state this cycle
- in_halt  input  1  halt request (syscall), level, sampled each cycle
- in_go  input  1  resume pulse, honoured only in HALT
- out_pc  output  32  current PC (registered)
- out_pcc  output  32  out_pc + 4 (combinational, modulo 2^32)
- out_flush  output  1  registered; high while in FLUSH, squashes decode
- out_halted  output  1  registered; high while in HALT

Behaviour:
- Reset: sampled on the clock edge when in_rst_n=0. out_pc=RESET_VECTOR, state=RUN, out_flush=0, out_halted=0, jump counter=0. Reset overrides every other input, including mid-FLUSH and mid-HALT.
- Direct target: {out_pc[31:JFIELD_W], in_is[JFIELD_W-1:0]}.
- JR target: in_a, used unmodified with no alignment.
- Selected target: in_JR ? JR target : direct target.
- Priority in RUN: halt > stall > jump > sequential.
- RUN, in_halt=1:
  - Next state HALT; PC holds.
  - Any in_J in the same cycle is dropped.
- RUN, in_stall=1, no halt: PC and state hold; in_J and in_JR are ignored.
- RUN, in_J=1:
  - PC <= selected target; next state FLUSH.
  - Latency: target visible on out_pc one cycle after in_J is sampled.
- RUN, otherwise: PC <= out_pcc.
- FLUSH:
  - out_flush=1.
  - in_J, in_JR and in_halt are ignored.
  - If in_stall=1: PC and state hold.
  - Else: PC <= out_pcc, next state RUN.
  - A jump is therefore never taken on two consecutive cycles.
- HALT:
  - out_halted=1; PC holds.
  - in_stall and in_J are ignored.
  - in_go=1: next state RUN, PC <= out_pcc (resume after the halting instruction).
  - If in_halt is still high on return to RUN, HALT is re-entered on the next cycle.
- Wrap-around: PC 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag.
- States are encoded in 2 bits; the unused code returns to RUN on the next clock with PC held.

Optional Feature:
- Macro: PC_SEQ_JCNT_EN.
- When defined:
  - Adds output port out_jcnt, 16 bits, reset to 0.
  - Increments by 1 on every taken jump (RUN, no halt, no stall, in_J=1).
  - Saturates at 16'hFFFF; a jump at saturation leaves it at 16'hFFFF.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then free-run, no requests, RESET_VECTOR=0 -> out_pc sequence 0,4,8,C on successive edges; out_flush=0 throughout.
- Direct jump:
  - Stimulus: PC=32'h0000_1230, in_J=1, in_JR=0, in_is[7:0]=8'h40.
  - Response: next out_pc=32'h0000_1240, out_flush=1 for exactly one cycle, then out_pc=32'h0000_1244.
- JR with simultaneous stall:
  - Stimulus: in_J=1, in_JR=1, in_a=32'hDEAD_BEE0, in_stall=1 for 2 cycles, then in_stall=0.
  - Response: PC held 2 cycles, then out_pc=32'hDEAD_BEE0.
  - JR held but also asserted during the following FLUSH is ignored.
- Halt beats jump:
  - Stimulus: in_halt=1 and in_J=1 in the same cycle at PC=32'h100.
  - Response: out_halted=1, out_pc stays 32'h100.
  - in_go pulse (halt dropped) -> RUN, out_pc=32'h104.
- Wrap and reset mid-FLUSH:
  - Stimulus: PC=32'hFFFF_FFFC, then in_rst_n=0 during a FLUSH cycle.
  - Response: out_pc=0 after the wrap; the reset edge gives out_pc=RESET_VECTOR, out_flush=0.
- PC_SEQ_JCNT_EN defined:
  - Stimulus: force out_jcnt to 16'hFFFE, then take 3 jumps.
  - Response: out_jcnt 16'hFFFF, 16'hFFFF, 16'hFFFF; a stalled jump does not count.

Source files
------------

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Owns the program counter of the single-issue CPU. Each cycle it picks the
// next PC from one of three sources:
//   - sequential:    PC + 4
//   - direct jump:   low JFIELD_W bits of the instruction spliced into the PC
//   - register jump: the register operand in_a (JR)
// Every taken jump is followed by a one-cycle FLUSH bubble that squashes
// decode. The block also supports a stall hold and a halt/resume handshake
// with the control unit.
//
// Parameters:
//   RESET_VECTOR  PC value loaded on reset
//   JFIELD_W      width of the direct-jump field in the instruction (1..30)
//
// Ports:
//   in_clk      system clock, rising edge
//   in_rst_n    synchronous active-low reset
//   in_J        jump request from decode
//   in_JR       with in_J: register jump (target = in_a)
//   in_a        register-file operand for JR
//   in_is       instruction word in decode
//   in_stall    hold PC and state this cycle
//   in_halt     halt request (level)
//   in_go       resume pulse, honoured only while halted
//   out_jcnt    taken-jump counter, saturating (PC_SEQ_JCNT_EN only)
//   out_pc      current PC (registered)
//   out_pcc     out_pc + 4 (combinational, wraps modulo 2^32)
//   out_flush   high while in the FLUSH bubble
//   out_halted  high while halted
//
// Build option:
//   PC_SEQ_JCNT_EN  adds the 16-bit saturating taken-jump counter out_jcnt
// -----------------------------------------------------------------------------
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned JFIELD_W     = 8
) (
    input  logic        in_clk,
    input  logic        in_rst_n,
    input  logic        in_J,
    input  logic        in_JR,
    input  logic [31:0] in_a,
    input  logic [31:0] in_is,
    input  logic        in_stall,
    input  logic        in_halt,
    input  logic        in_go,
`ifdef PC_SEQ_JCNT_EN
    output logic [15:0] out_jcnt,
`endif
    output logic [31:0] out_pc,
    output logic [31:0] out_pcc,
    output logic        out_flush,
    output logic        out_halted
);

    localparam logic [1:0] ST_RUN   = 2'b00;
    localparam logic [1:0] ST_FLUSH = 2'b01;
    localparam logic [1:0] ST_HALT  = 2'b10;

    // Bits of the PC replaced by the instruction field on a direct jump.
    localparam logic [31:0] JMASK = (32'd1 << JFIELD_W) - 32'd1;

    logic [31:0] pc_q, pc_d;
    logic [1:0]  state_q, state_d;
    logic        flush_q, halted_q;
    logic [31:0] pc_inc;
    logic [31:0] jtarget;

    assign pc_inc  = pc_q + 32'd4;
    assign jtarget = in_JR ? in_a : ((pc_q & ~JMASK) | (in_is & JMASK));

    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                // halt > stall > jump > sequential; a jump alongside halt is dropped
                if (in_halt) begin
                    state_d = ST_HALT;
                end else if (in_stall) begin
                    state_d = ST_RUN;
                end else if (in_J) begin
                    pc_d    = jtarget;
                    state_d = ST_FLUSH;
                end else begin
                    pc_d = pc_inc;
                end
            end
            ST_FLUSH: begin
                // Jump and halt requests are ignored inside the bubble.
                if (!in_stall) begin
                    pc_d    = pc_inc;
                    state_d = ST_RUN;
                end
            end
            ST_HALT: begin
                if (in_go) begin
                    pc_d    = pc_inc;
                    state_d = ST_RUN;
                end
            end
            default: begin
                // Unused code: recover to RUN with the PC held.
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            pc_q     <= RESET_VECTOR;
            state_q  <= ST_RUN;
            flush_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            state_q  <= state_d;
            // Status flags registered from the next state so they track state_q.
            flush_q  <= (state_d == ST_FLUSH);
            halted_q <= (state_d == ST_HALT);
        end
    end

`ifdef PC_SEQ_JCNT_EN
    logic        jump_taken;
    logic [15:0] jcnt_q;

    assign jump_taken = (state_q == ST_RUN) && !in_halt && !in_stall && in_J;

    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            jcnt_q <= '0;
        end else if (jump_taken && (jcnt_q != '1)) begin
            jcnt_q <= jcnt_q + 16'd1;
        end
    end

    assign out_jcnt = jcnt_q;
`endif

    assign out_pc     = pc_q;
    assign out_pcc    = pc_inc;
    assign out_flush  = flush_q;
    assign out_halted = halted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam int unsigned JW = 8;

    logic        clk;
    logic        rst_n;
    logic        J, JR, stall, halt, go;
    logic [31:0] a, is;
    logic [31:0] pc, pcc;
    logic        flush, halted;
`ifdef PC_SEQ_JCNT_EN
    logic [15:0] jcnt;
`endif

    pc_sequencer #(.RESET_VECTOR(RV), .JFIELD_W(JW)) dut (
        .in_clk    (clk),
        .in_rst_n  (rst_n),
        .in_J      (J),
        .in_JR     (JR),
        .in_a      (a),
        .in_is     (is),
        .in_stall  (stall),
        .in_halt   (halt),
        .in_go     (go),
`ifdef PC_SEQ_JCNT_EN
        .out_jcnt  (jcnt),
`endif
        .out_pc    (pc),
        .out_pcc   (pcc),
        .out_flush (flush),
        .out_halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Behavioural model: "in bubble" / "halted" flags plus PC and jump count.
    logic [31:0] m_pc;
    bit          m_bubble, m_halted;
    int          m_jumps;

    always @(posedge clk) begin
        logic [31:0] mask;
        mask = (32'd1 << JW) - 32'd1;
        if (!rst_n) begin
            m_pc = RV; m_bubble = 0; m_halted = 0; m_jumps = 0;
        end else if (m_halted) begin
            if (go) begin m_halted = 0; m_pc = m_pc + 32'd4; end
        end else if (m_bubble) begin
            if (!stall) begin m_bubble = 0; m_pc = m_pc + 32'd4; end
        end else if (halt) begin
            m_halted = 1;
        end else if (stall) begin
            // hold
        end else if (J) begin
            m_pc = JR ? a : ((m_pc & ~mask) | (is & mask));
            m_bubble = 1;
            if (m_jumps < 65535) m_jumps++;
        end else begin
            m_pc = m_pc + 32'd4;
        end
    end

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk32("model_pc", pc, m_pc);
            chk32("model_pcc", pcc, m_pc + 32'd4);
            chk32("model_flush", {31'd0, flush}, {31'd0, m_bubble});
            chk32("model_halted", {31'd0, halted}, {31'd0, m_halted});
`ifdef PC_SEQ_JCNT_EN
            chk32("model_jcnt", {16'd0, jcnt}, m_jumps[31:0]);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input logic [31:0] epc, input logic ef, input logic eh);
        chk32({name, "_pc"}, pc, epc);
        chk32({name, "_flush"}, {31'd0, flush}, {31'd0, ef});
        chk32({name, "_halted"}, {31'd0, halted}, {31'd0, eh});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; J = 0; JR = 0; stall = 0; halt = 0; go = 0; a = '0; is = '0;
        step(); step();
        chk_en = 1;
        lit("reset", 32'h0, 1'b0, 1'b0);

        // Free run
        rst_n = 1;
        step(); lit("seq4", 32'h4, 1'b0, 1'b0);
        step(); lit("seq8", 32'h8, 1'b0, 1'b0);
        step(); lit("seqC", 32'hC, 1'b0, 1'b0);

        // Get to PC 0x1230 via JR to 0x122C
        J = 1; JR = 1; a = 32'h0000_122C;
        step(); lit("jr_122c", 32'h122C, 1'b1, 1'b0);
        J = 0; JR = 0;
        step(); lit("pc_1230", 32'h1230, 1'b0, 1'b0);

        // Direct jump
        J = 1; JR = 0; is = 32'hABCD_EF40;
        step(); lit("dj_1240", 32'h1240, 1'b1, 1'b0);
        J = 0;
        step(); lit("dj_1244", 32'h1244, 1'b0, 1'b0);

        // JR with stall, JR held through the flush
        J = 1; JR = 1; a = 32'hDEAD_BEE0; stall = 1;
        step(); lit("jrst1", 32'h1244, 1'b0, 1'b0);
        step(); lit("jrst2", 32'h1244, 1'b0, 1'b0);
        stall = 0;
        step(); lit("jr_dead", 32'hDEAD_BEE0, 1'b1, 1'b0);
        step(); lit("jr_flushign", 32'hDEAD_BEE4, 1'b0, 1'b0);

        // Stall inside the flush bubble holds it
        a = 32'h0000_0200;
        step(); lit("jr_200", 32'h200, 1'b1, 1'b0);
        J = 0; JR = 0; stall = 1;
        step(); lit("flush_stall", 32'h200, 1'b1, 1'b0);
        stall = 0;
        step(); lit("flush_exit", 32'h204, 1'b0, 1'b0);

        // Halt beats jump at PC 0x100
        J = 1; JR = 1; a = 32'h0000_00FC;
        step(); J = 0; JR = 0;
        step(); lit("pc_100", 32'h100, 1'b0, 1'b0);
        halt = 1; J = 1; JR = 1; a = 32'h0000_5000;
        step(); lit("halt_in", 32'h100, 1'b0, 1'b1);
        halt = 0; stall = 1;
        step(); lit("halt_hold", 32'h100, 1'b0, 1'b1);
        J = 0; JR = 0; stall = 0; go = 1;
        step(); lit("resume", 32'h104, 1'b0, 1'b0);
        go = 0;

        // Halt still high on resume re-enters HALT
        halt = 1;
        step(); lit("rehalt1", 32'h104, 1'b0, 1'b1);
        go = 1;
        step(); lit("rehalt_go", 32'h108, 1'b0, 1'b0);
        go = 0;
        step(); lit("rehalt2", 32'h108, 1'b0, 1'b1);
        halt = 0; go = 1;
        step(); lit("rehalt_out", 32'h10C, 1'b0, 1'b0);
        // go outside HALT has no effect
        step(); lit("go_in_run", 32'h110, 1'b0, 1'b0);
        go = 0;

        // Wrap-around
        J = 1; JR = 1; a = 32'hFFFF_FFF8;
        step(); J = 0; JR = 0;
        step(); lit("pc_fffc", 32'hFFFF_FFFC, 1'b0, 1'b0);
        chk32("pcc_wrap", pcc, 32'h0);
        step(); lit("wrap0", 32'h0, 1'b0, 1'b0);

        // Reset mid-FLUSH
        J = 1; JR = 1; a = 32'h0000_0040;
        step(); lit("jr_40", 32'h40, 1'b1, 1'b0);
        J = 0; JR = 0; rst_n = 0;
        step(); lit("rst_flush", RV, 1'b0, 1'b0);
        rst_n = 1;
        step(); step();

        // Reset mid-HALT
        halt = 1;
        step(); lit("halt_pre_rst", 32'h8, 1'b0, 1'b1);
        halt = 0; rst_n = 0;
        step(); lit("rst_halt", RV, 1'b0, 1'b0);
        rst_n = 1;
        step(); lit("post_rst", 32'h4, 1'b0, 1'b0);

`ifdef PC_SEQ_JCNT_EN
        force dut.jcnt_q = 16'hFFFE;
        #1;
        release dut.jcnt_q;
        m_jumps = 32'hFFFE;
        for (int k = 0; k < 3; k++) begin
            J = 1; JR = 1; a = 32'h0000_1000;
            step(); J = 0; JR = 0;
            step();
            chk32("jcnt_sat", {16'd0, jcnt}, 32'h0000_FFFF);
        end
        rst_n = 0; step(); rst_n = 1;
        J = 1; stall = 1;
        step(); chk32("jcnt_stall", {16'd0, jcnt}, 32'h0);
        stall = 0;
        step(); chk32("jcnt_one", {16'd0, jcnt}, 32'h1);
        J = 0;
        step();
`endif

        step();
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
